// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer handshake and FIFO write-port bundle; master is the arbiter side.
interface fifo_wr_arb_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int DW    = DEF_DW
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                fifo_full;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_wr_data;
    logic                grant_vld;
    logic [IW-1:0]       grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1 with wrap.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int          IW = $clog2(N);
    localparam int unsigned NU = N;

    always_comb begin
        int unsigned    pos;
        logic [IW-1:0]  cand;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int unsigned i = 1; i <= NU; i++) begin
            pos  = (32'(last) + i) % NU;
            cand = IW'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one syn_fifo write port between N_REQ producers,
// granting one producer at a time for a burst of at most MAX_BURST beats.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          rstn,
    fifo_wr_arb_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [CW-1:0] beat_cnt;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [DW-1:0] data_arr [N_REQ];
    logic          own_valid;
    logic          beat;
    logic          burst_done;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = bus.req_data[g*DW +: DW];
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (bus.req_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        own_valid  = bus.req_valid[owner];
        beat       = (state == BURST) && own_valid && !bus.fifo_full;
        burst_done = (state == BURST) && (!own_valid || (beat && (beat_cnt == LAST_BEAT)));
    end

    // fifo_full reaches req_ready/fifo_wr_en combinationally so a full FIFO stalls the same cycle.
    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        if (state == BURST) begin
            bus.req_ready[owner] = ~bus.fifo_full;
            bus.fifo_wr_en       = beat;
            if (beat) begin
                bus.fifo_wr_data = data_arr[owner];
            end
        end
    end

    assign bus.grant_vld = (state == BURST);
    assign bus.grant_id  = owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= LAST_INIT;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick_idx;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (burst_done) begin
                        state    <= IDLE;
                        last     <= owner;
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: producers are modelled as data queues, FIFO writes are checked in order.
module tb_fifo_wr_arb;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arb_if #(.N_REQ(N), .DW(DW)) bus ();

    fifo_wr_arb #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [7:0]  pdata [N][16];
    int unsigned phead [N];
    int unsigned pcnt  [N];
    logic [N-1:0] beat_seen = '0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol checks and in-order comparison of every FIFO write.
    always @(negedge clk) begin
        if (rstn) begin
            beat_seen <= bus.req_valid & bus.req_ready;
            chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
            if (bus.fifo_full) chk("wr_en_while_full", 32'(bus.fifo_wr_en), 0);
            if (bus.fifo_wr_en) begin
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", 32'(bus.fifo_wr_data), 32'(mon_e.data));
                    chk("wr_owner", 32'(bus.grant_id), 32'(mon_e.id));
                end
            end
        end else begin
            beat_seen <= '0;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (phead[i] < pcnt[i]) begin
                bus.req_valid[i]          = 1'b1;
                bus.req_data[i*DW +: DW]  = pdata[i][phead[i]];
            end else begin
                bus.req_valid[i]          = 1'b0;
                bus.req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (beat_seen[i]) phead[i]++;
        end
        drive();
    endtask

    task automatic add(input int p, input logic [7:0] d);
        pdata[p][pcnt[p]] = d;
        pcnt[p]++;
    endtask

    task automatic expect_beat(input logic [7:0] d, input int p);
        beat_t e;
        e.data = d;
        e.id   = 2'(p);
        exp_q.push_back(e);
    endtask

    task automatic check_grant(input logic ev, input int eid);
        chk("grant_vld", 32'(bus.grant_vld), 32'(ev));
        if (ev) chk("grant_id", 32'(bus.grant_id), 32'(eid));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        chk({tag, "_wr_data"}, 32'(bus.fifo_wr_data), 0);
        chk({tag, "_grant_vld"}, 32'(bus.grant_vld), 0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            pcnt[i]  = 0;
        end
        bus.fifo_full = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic       done;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        do_reset();
        check_outputs_zero("reset");

        // Single producer: 4-beat burst, idle bubble, then one more beat.
        for (int k = 0; k < 5; k++) begin
            add(0, 8'(8'h11 * (k + 1)));
            expect_beat(8'(8'h11 * (k + 1)), 0);
        end
        drive();
        pat = 8'b0110_1111;
        for (int s = 1; s <= 8; s++) begin
            step();
            check_grant(pat[s-1], 0);
        end
        chk("t1_drained", 32'(exp_q.size()), 0);

        // All four valid: rotation 0,1,2,3,0 with 4 beats each and one idle cycle between.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 4; k++) begin
                add(i, 8'((i + 1) * 16 + k));
                expect_beat(8'((i + 1) * 16 + k), i);
            end
        end
        add(0, 8'h14);
        expect_beat(8'h14, 0);
        drive();
        for (int s = 1; s <= 23; s++) begin
            step();
            check_grant((s % 5 != 0) && (s <= 22), (s / 5) % 4);
        end
        chk("t2_drained", 32'(exp_q.size()), 0);

        // FIFO full for 3 cycles after beat 2 of producer 1; producer 2 must wait.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add(1, 8'(8'hB1 + k));
            expect_beat(8'(8'hB1 + k), 1);
        end
        add(2, 8'hC1);
        expect_beat(8'hC1, 2);
        drive();
        for (int s = 1; s <= 3; s++) begin
            step();
            check_grant(1'b1, 1);
        end
        bus.fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("full_req_ready", 32'(bus.req_ready), 0);
            chk("full_wr_en", 32'(bus.fifo_wr_en), 0);
            step();
            check_grant(1'b1, 1);
        end
        bus.fifo_full = 1'b0;
        step(); check_grant(1'b1, 1);
        step(); check_grant(1'b0, 0);
        step(); check_grant(1'b1, 2);
        step(); check_grant(1'b1, 2);
        step(); check_grant(1'b0, 0);
        chk("t3_drained", 32'(exp_q.size()), 0);

        // Early drop by producer 2; producer 3 beats producer 0 because last=2.
        do_reset();
        add(2, 8'hD1);
        add(3, 8'hE1);
        add(3, 8'hE2);
        expect_beat(8'hD1, 2);
        expect_beat(8'hE1, 3);
        expect_beat(8'hE2, 3);
        expect_beat(8'hF1, 0);
        drive();
        step(); check_grant(1'b1, 2);
        add(0, 8'hF1);
        drive();
        step(); check_grant(1'b1, 2);
        step(); check_grant(1'b0, 0);
        step(); check_grant(1'b1, 3);
        step(); check_grant(1'b1, 3);
        step(); check_grant(1'b1, 3);
        step(); check_grant(1'b0, 0);
        step(); check_grant(1'b1, 0);
        step(); check_grant(1'b1, 0);
        step(); check_grant(1'b0, 0);
        chk("t4_drained", 32'(exp_q.size()), 0);

        // Reset during beat 2 of producer 0; afterwards producer 0 wins over pending producer 3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add(0, 8'(8'h91 + k));
            expect_beat(8'(8'h91 + k), 0);
        end
        add(3, 8'h9F);
        expect_beat(8'h9F, 3);
        drive();
        step(); check_grant(1'b1, 0);
        step(); check_grant(1'b1, 0);
        rstn = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(); check_grant(1'b1, 0);
        done = 1'b0;
        for (int s = 0; s < 40 && !done; s++) begin
            step();
            done = (exp_q.size() == 0) && (phead[0] == pcnt[0]) && (phead[3] == pcnt[3]);
        end
        chk("t5_drain_in_time", 32'(done), 1);
        chk("t5_drained", 32'(exp_q.size()), 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
